// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the I2S audio output path: frame geometry, sample
// types and the 3:1 centred-mix arithmetic used by audio_mix.
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int AUD_FRAME_BITS = 32;
  localparam int AUD_SLOT_BITS  = 16;
  localparam int AUD_BITCNT_W   = $clog2(AUD_FRAME_BITS);

  typedef logic signed [14:0]              sample15_t;
  typedef logic signed [AUD_SLOT_BITS-1:0] sample16_t;

  // One serial frame, left slot in the upper half so it leaves the MSB first.
  typedef struct packed {
    sample16_t left;
    sample16_t right;
  } frame_t;

  // (3*own + other) >>> 2 in 18-bit signed arithmetic. The worst-case sum
  // 4 * -32768 = -131072 still fits 18 bits, so no saturation is required;
  // taking bits [17:2] is the arithmetic shift plus truncation to 16 bits.
  function automatic sample16_t mix_3_1(input sample16_t own, input sample16_t other);
    logic signed [17:0] own18;
    logic signed [17:0] other18;
    logic signed [17:0] acc;
    own18   = 18'(own);
    other18 = 18'(other);
    acc     = (own18 <<< 1) + own18 + other18;
    return acc[17:2];
  endfunction

endpackage

// File: rtl/audio_mix.sv
// -----------------------------------------------------------------------------
// audio_mix
// Combinational sample conditioning for one I2S frame: optional left/right
// exchange, left-justification to 16 bits, optional 3:1 centred mix and mute.
//
// Ports:
//   ldata, rdata  in  SAMPLE_W signed  upstream left/right samples
//   exchan        in  1                swap channels before mixing
//   mix           in  1                out = (3*own + other)/4
//   mute          in  1                force both slots to zero
//   frame         out frame_t          {left, right} 16-bit slot words
// -----------------------------------------------------------------------------
module audio_mix
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 15
) (
  input  logic signed [SAMPLE_W-1:0] ldata,
  input  logic signed [SAMPLE_W-1:0] rdata,
  input  logic                       exchan,
  input  logic                       mix,
  input  logic                       mute,
  output frame_t                     frame
);

  // Samples are left-justified into the 16-bit slot (15-bit input gets one
  // zero LSB); SAMPLE_W must not exceed AUD_SLOT_BITS.
  localparam int PAD = AUD_SLOT_BITS - SAMPLE_W;

  logic signed [SAMPLE_W-1:0] own_a;
  logic signed [SAMPLE_W-1:0] own_b;
  sample16_t                  a16;
  sample16_t                  b16;

  always_comb begin
    own_a = exchan ? rdata : ldata;
    own_b = exchan ? ldata : rdata;
    a16   = sample16_t'(own_a) <<< PAD;
    b16   = sample16_t'(own_b) <<< PAD;

    frame = '0;
    if (!mute) begin
      if (mix) begin
        frame.left  = mix_3_1(a16, b16);
        frame.right = mix_3_1(b16, a16);
      end else begin
        frame.left  = a16;
        frame.right = b16;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_shifter.sv
// -----------------------------------------------------------------------------
// audio_i2s_shifter
// I2S master transmitter for the WM8731 DAC. Generates MCLK (clk/2), BCLK
// (clk/(2*BCLK_DIV)) and LRCLK (BCLK/32), and shifts one 32-bit {L,R} frame
// out MSB first with the standard one-BCLK I2S delay after each LRCLK edge.
// Upstream inputs are sampled once per frame, in the same clk that the
// frame wraps, and that clk is flagged on sample_strobe.
//
// Ports:
//   clk            in   system clock (sole clock)
//   rst_n          in   asynchronous active-low reset
//   ldata, rdata   in   signed samples, latched at frame wrap
//   exchan         in   swap left/right (latched at frame wrap)
//   mix            in   centred 3:1 mix (latched at frame wrap)
//   mute           in   transmit zeros (latched at frame wrap)
//   aud_xck        out  codec master clock, clk/2
//   aud_bclk       out  I2S bit clock
//   aud_daclrck    out  0 = left slot, 1 = right slot
//   aud_dacdat     out  serial data, changes on BCLK falling edge
//   sample_strobe  out  one-clk pulse when a new frame is latched
// -----------------------------------------------------------------------------
module audio_i2s_shifter
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 9,
  parameter int SAMPLE_W = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] ldata,
  input  logic signed [SAMPLE_W-1:0] rdata,
  input  logic                       exchan,
  input  logic                       mix,
  input  logic                       mute,
  output logic                       aud_xck,
  output logic                       aud_bclk,
  output logic                       aud_daclrck,
  output logic                       aud_dacdat,
  output logic                       sample_strobe
);

  localparam int              DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [AUD_BITCNT_W-1:0] bit_cnt;
  logic [AUD_BITCNT_W-1:0] bit_cnt_next;
  frame_t                  sreg;
  frame_t                  frame_p0;
  logic                    div_tc;
  logic                    fall_evt;
  logic                    frame_wrap;

  audio_mix #(
    .SAMPLE_W (SAMPLE_W)
  ) u_mix (
    .ldata  (ldata),
    .rdata  (rdata),
    .exchan (exchan),
    .mix    (mix),
    .mute   (mute),
    .frame  (frame_p0)
  );

  assign div_tc       = (div_cnt == DIV_LAST);
  // BCLK is about to toggle 1->0: this is the only point data/LRCLK move.
  assign fall_evt     = div_tc & aud_bclk;
  assign frame_wrap   = fall_evt & (bit_cnt == '1);
  assign bit_cnt_next = bit_cnt + 1'b1;

  // ---- clock generation: MCLK and BCLK ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aud_xck  <= 1'b0;
      aud_bclk <= 1'b0;
      div_cnt  <= '0;
    end else begin
      aud_xck <= ~aud_xck;
      if (div_tc) begin
        div_cnt  <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ---- serialiser: slot counter, LRCLK, shift register, frame latch ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      aud_daclrck   <= 1'b0;
      aud_dacdat    <= 1'b0;
      sreg          <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_wrap;
      if (fall_evt) begin
        bit_cnt     <= bit_cnt_next;
        aud_daclrck <= bit_cnt_next[AUD_BITCNT_W-1];
        // Slot 0 still carries the last right bit of the old frame; the new
        // frame is loaded behind it, giving the one-BCLK I2S delay.
        aud_dacdat  <= sreg[AUD_FRAME_BITS-1];
        if (frame_wrap) begin
          sreg <= frame_p0;
        end else begin
          sreg <= {sreg[AUD_FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_shifter.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_shifter
// Directed and randomized stimulus for audio_i2s_shifter. Expected frames come
// from an integer-arithmetic model of the sample rules; expected timing comes
// from closed-form clock-count formulas.
// -----------------------------------------------------------------------------
module tb_audio_i2s_shifter;

  localparam int DIV        = 9;
  localparam int FRAME_CLKS = 32 * 2 * DIV;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [14:0] ldata;
  logic signed [14:0] rdata;
  logic               exchan;
  logic               mix;
  logic               mute;
  logic               aud_xck;
  logic               aud_bclk;
  logic               aud_daclrck;
  logic               aud_dacdat;
  logic               sample_strobe;

  int n_assert = 0;
  int n_fail   = 0;

  audio_i2s_shifter #(
    .BCLK_DIV (DIV),
    .SAMPLE_W (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ldata         (ldata),
    .rdata         (rdata),
    .exchan        (exchan),
    .mix           (mix),
    .mute          (mute),
    .aud_xck       (aud_xck),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: sample value as an integer, doubled for the 16-bit slot,
  // floor-divided by 4 for the mix, low 16 bits transmitted.
  function automatic logic [31:0] model(input logic [14:0] l, input logic [14:0] r,
                                        input logic x, input logic m, input logic mu);
    int a;
    int b;
    int lo;
    int ro;
    a = 2 * (x ? int'($signed(r)) : int'($signed(l)));
    b = 2 * (x ? int'($signed(l)) : int'($signed(r)));
    if (m) begin
      lo = (3 * a + b) >>> 2;
      ro = (3 * b + a) >>> 2;
    end else begin
      lo = a;
      ro = b;
    end
    if (mu) return 32'h0;
    return {lo[15:0], ro[15:0]};
  endfunction

  function automatic logic [14:0] pick_sample();
    case ($urandom_range(0, 3))
      0:       return 15'h4000;
      1:       return 15'h3FFF;
      default: return 15'($urandom);
    endcase
  endfunction

  // Releases reset and checks two full frames of timing against closed-form
  // expectations, plus the data of the first frame latched after reset.
  task automatic run_from_reset(input string tag);
    int bad_xck = 0;
    int bad_bclk = 0;
    int bad_lr = 0;
    int bad_stb = 0;
    int bad_dat = 0;
    int first_rise = -1;
    int f;
    logic [31:0] word = '0;
    logic [31:0] exp;
    exp = model(ldata, rdata, exchan, mix, mute);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 2 * FRAME_CLKS; c++) begin
      @(posedge clk); #1;
      f = c / (2 * DIV);
      if (aud_xck !== c[0]) bad_xck++;
      if (aud_bclk !== 1'(((c / DIV) % 2))) bad_bclk++;
      if (first_rise < 0 && aud_bclk === 1'b1) first_rise = c;
      if (aud_daclrck !== ((f % 32) >= 16)) bad_lr++;
      if (sample_strobe !== ((c % FRAME_CLKS) == 0)) bad_stb++;
      if (c <= FRAME_CLKS && aud_dacdat !== 1'b0) bad_dat++;
      if ((c % (2 * DIV)) == 0 && f > 32) word = {word[30:0], aud_dacdat};
    end
    check({tag, "_bclk_first_rise"}, first_rise, DIV);
    check({tag, "_xck_bad_cycles"}, bad_xck, 0);
    check({tag, "_bclk_bad_cycles"}, bad_bclk, 0);
    check({tag, "_lrck_bad_cycles"}, bad_lr, 0);
    check({tag, "_strobe_bad_cycles"}, bad_stb, 0);
    check({tag, "_zero_frame_bad_bits"}, bad_dat, 0);
    check({tag, "_first_frame"}, word, exp);
  endtask

  // Called in the clk of a strobe; collects the 32 bits of the frame latched
  // there (slots 1..31 plus the next slot 0). At fall number change_at the
  // inputs are replaced, which must only affect the following frame.
  task automatic capture(input string tag, input int change_at,
                         input logic [14:0] nl, input logic [14:0] nr,
                         input logic nx, input logic nm, input logic nmu,
                         output logic [31:0] word);
    int falls = 0;
    int cyc = 0;
    int bad_lr = 0;
    int bad_stb = 0;
    logic prev;
    word = '0;
    prev = aud_bclk;
    while (falls < 32 && cyc < FRAME_CLKS + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (prev === 1'b1 && aud_bclk === 1'b0) begin
        falls++;
        word = {word[30:0], aud_dacdat};
        if (aud_daclrck !== ((falls % 32) >= 16)) bad_lr++;
        if (sample_strobe !== (falls == 32)) bad_stb++;
        if (falls == change_at) begin
          ldata = nl; rdata = nr; exchan = nx; mix = nm; mute = nmu;
        end
      end else if (sample_strobe !== 1'b0) begin
        bad_stb++;
      end
      prev = aud_bclk;
    end
    check({tag, "_frame_clks"}, cyc, FRAME_CLKS);
    check({tag, "_lrck_bad_slots"}, bad_lr, 0);
    check({tag, "_strobe_bad"}, bad_stb, 0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp;
    logic [14:0] nl;
    logic [14:0] nr;
    logic        nx;
    logic        nm;
    logic        nmu;
    int          falls;
    logic        prev;

    rst_n = 1'b0; ldata = 15'h4000; rdata = 15'h7FFF; exchan = 1'b0; mix = 1'b0; mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, sample_strobe}, 0);

    // Timing from reset; ends in the clk of the second strobe.
    run_from_reset("boot");

    // Plain frame; exchange switched on late in the frame.
    exp = model(ldata, rdata, exchan, mix, mute);
    capture("plain", 20, 15'h4000, 15'h7FFF, 1'b1, 1'b0, 1'b0, word);
    check("plain_data", word, 32'h8000FFFE);
    check("plain_model", word, exp);

    // Exchanged frame; data and mix changed at slot 8 must not disturb it.
    capture("exch", 8, 15'h3FFF, 15'h4001, 1'b0, 1'b1, 1'b0, word);
    check("exch_data", word, 32'hFFFE8000);

    // Mixed frame; mute raised mid-frame only affects the next one.
    capture("mix", 8, 15'h3FFF, 15'h4001, 1'b0, 1'b1, 1'b1, word);
    check("mix_data", word, 32'h3FFFC001);

    capture("mute", 5, pick_sample(), pick_sample(), 1'b0, 1'b0, 1'b0, word);
    check("mute_data", word, 32'h0);

    // Randomized frames, inputs replaced at a random slot each time.
    for (int k = 0; k < 12; k++) begin
      exp = model(ldata, rdata, exchan, mix, mute);
      nl  = pick_sample();
      nr  = pick_sample();
      nx  = 1'($urandom_range(0, 1));
      nm  = 1'($urandom_range(0, 1));
      nmu = ($urandom_range(0, 3) == 0);
      capture("rand", $urandom_range(1, 30), nl, nr, nx, nm, nmu, word);
      check("rand_data", word, exp);
    end

    // Reset in the middle of a frame at bit 20.
    falls = 0;
    prev  = aud_bclk;
    for (int c = 0; c < FRAME_CLKS && falls < 20; c++) begin
      @(posedge clk); #1;
      if (prev === 1'b1 && aud_bclk === 1'b0) falls++;
      prev = aud_bclk;
    end
    check("midreset_reached_bit20", falls, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async_outputs", {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, sample_strobe}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midreset_held_outputs", {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, sample_strobe}, 0);
    run_from_reset("restart");

    exp = model(ldata, rdata, exchan, mix, mute);
    capture("post", 0, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, word);
    check("post_data", word, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
